// File: rtl/vote_sampler.sv
// 3-sample windowing stage feeding the 2-of-3 majority detector (sliding or block windows).
// Optional window counter port win_count is compiled in with VOTE_SAMPLER_COUNT_EN.
module vote_sampler #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_val,
  input  logic             in_bit,
  input  logic             mode,
  output logic             out0,
  output logic             out1,
  output logic             out2,
`ifdef VOTE_SAMPLER_COUNT_EN
  output logic [CNT_W-1:0] win_count,
`endif
  output logic             out_val
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;
  localparam logic [1:0] FULL  = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [2:0] r_s;
  logic       w_accept;
  logic       w_emit;

  assign w_accept = in_val & ~clear;

  // Fill tracking; a sample completing a window emits it, block mode then restarts the fill.
  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    if (clear) begin
      w_next_state = EMPTY;
    end else if (w_accept) begin
      case (r_state)
        EMPTY:   w_next_state = ONE;
        ONE:     w_next_state = TWO;
        default: begin
          w_emit       = 1'b1;
          w_next_state = mode ? EMPTY : FULL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_s     <= 3'b000;
      out0    <= 1'b0;
      out1    <= 1'b0;
      out2    <= 1'b0;
      out_val <= 1'b0;
    end else begin
      r_state <= w_next_state;
      out_val <= w_emit;
      if (clear) begin
        r_s <= 3'b000;
      end else if (w_accept) begin
        r_s <= {r_s[1:0], in_bit};
      end
      // Window is the post-shift contents; held until the next emission.
      if (w_emit) begin
        out0 <= r_s[1];
        out1 <= r_s[0];
        out2 <= in_bit;
      end
    end
  end

`ifdef VOTE_SAMPLER_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  // Saturating count of emitted windows.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (w_emit && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign win_count = r_cnt;
`endif

endmodule
